// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter
// Shares one AES-128 cipher core among NREQ requesters. Requests are granted
// round-robin. The granted key/plaintext is latched into hold registers that
// feed the core directly. The core is started with a one-cycle load pulse, and
// the ciphertext is returned on a single response channel tagged with the
// requester id. A watchdog aborts a job whose core never signals done, so a
// hung core cannot block the requesters.
module aes_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_key,
    input  logic [NREQ*128-1:0] req_text,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [127:0]        resp_data,
    output logic                resp_err,
    output logic                core_ld,
    output logic [127:0]        core_key,
    output logic [127:0]        core_text_in,
    input  logic                core_done,
    input  logic [127:0]        core_text_out,
    output logic                busy,
    output logic [7:0]          err_cnt
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int SW = IDW + 1;
    // The abort is registered on the edge where the timer steps to TIMEOUT-1,
    // so the error response appears TIMEOUT+1 cycles after the accept.
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 2);
    localparam logic [IDW-1:0] ID_MAX     = IDW'(NREQ - 1);
    localparam logic [IDW-1:0] ID_ONE     = IDW'(1);
    localparam logic [SW-1:0]  NREQ_W     = SW'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_r;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  id_r;
    logic [127:0]    key_hold_r;
    logic [127:0]    text_hold_r;
    logic [127:0]    resp_data_r;
    logic [TW-1:0]   timer_r;
    logic            core_ld_r;
    logic            resp_valid_r;
    logic            resp_err_r;
    logic [7:0]      err_cnt_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_id_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [NREQ-1:0] grant_onehot_s;
    logic [127:0]    sel_key_s;
    logic [127:0]    sel_text_s;
    logic            accept_s;
    logic            done_ok_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [SW-1:0]  sum_v;
        logic [SW-1:0]  wrap_v;
        logic [IDW-1:0] idx_v;
        logic           sel_v;
        sum_v         = {SW{1'b0}};
        wrap_v        = {SW{1'b0}};
        idx_v         = {IDW{1'b0}};
        sel_v         = 1'b0;
        grant_found_s = 1'b0;
        grant_id_s    = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            sum_v         = {1'b0, rr_ptr_r} + SW'(k);
            wrap_v        = (sum_v >= NREQ_W) ? (sum_v - NREQ_W) : sum_v;
            idx_v         = wrap_v[IDW-1:0];
            sel_v         = !grant_found_s && req_valid[idx_v];
            grant_id_s    = sel_v ? idx_v : grant_id_s;
            grant_found_s = grant_found_s | sel_v;
        end
    end

    // Select the granted requester's key and plaintext.
    always_comb begin
        sel_key_s  = 128'h0;
        sel_text_s = 128'h0;
        for (int k = 0; k < NREQ; k++) begin
            sel_key_s  = (grant_id_s == IDW'(k)) ? req_key[128*k +: 128]  : sel_key_s;
            sel_text_s = (grant_id_s == IDW'(k)) ? req_text[128*k +: 128] : sel_text_s;
        end
    end

    assign grant_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
    assign next_ptr_s     = (grant_id_s == ID_MAX) ? {IDW{1'b0}} : (grant_id_s + ID_ONE);
    assign accept_s       = rst && (state_r == ST_IDLE) && grant_found_s;
    // A done in the first BUSY cycle may belong to an aborted job.
    assign done_ok_s      = core_done && (timer_r != {TW{1'b0}});

    assign req_ready    = accept_s ? grant_onehot_s : {NREQ{1'b0}};
    assign resp_valid   = resp_valid_r;
    assign resp_id      = id_r;
    assign resp_data    = resp_data_r;
    assign resp_err     = resp_err_r;
    assign core_ld      = core_ld_r;
    assign core_key     = key_hold_r;
    assign core_text_in = text_hold_r;
    assign busy         = (state_r != ST_IDLE);
    assign err_cnt      = err_cnt_r;

    // Job sequencer: accept, load pulse, wait for done or watchdog, respond.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {IDW{1'b0}};
            id_r         <= {IDW{1'b0}};
            key_hold_r   <= 128'h0;
            text_hold_r  <= 128'h0;
            resp_data_r  <= 128'h0;
            timer_r      <= {TW{1'b0}};
            core_ld_r    <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_ld_r <= 1'b0;
                    if (accept_s) begin
                        key_hold_r  <= sel_key_s;
                        text_hold_r <= sel_text_s;
                        id_r        <= grant_id_s;
                        rr_ptr_r    <= next_ptr_s;
                        core_ld_r   <= 1'b1;
                        state_r     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    core_ld_r <= 1'b0;
                    timer_r   <= {TW{1'b0}};
                    state_r   <= ST_BUSY;
                end
                ST_BUSY: begin
                    core_ld_r <= 1'b0;
                    timer_r   <= timer_r + TW'(1);
                    if (done_ok_s) begin
                        resp_data_r  <= core_text_out;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= 1'b1;
                        state_r      <= ST_RESP;
                    end else if (timer_r == TIMER_LAST) begin
                        resp_data_r  <= 128'h0;
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= 1'b1;
                        err_cnt_r    <= (err_cnt_r == 8'hFF) ? 8'hFF : (err_cnt_r + 8'h01);
                        state_r      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    core_ld_r <= 1'b0;
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    core_ld_r    <= 1'b0;
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed testbench for aes_req_arbiter with a behavioural stand-in for the
// cipher core: done arrives 12 cycles after the load pulse. The FIPS-197
// vector returns its real ciphertext; other inputs use a simple mixing
// function, so each response can be traced to the job that produced it.
module tb_aes_req_arbiter;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;

    localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_BASE  = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = 4'b0000;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_key = '0;
    logic [NREQ*128-1:0] req_text = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [IDW-1:0]      resp_id;
    logic [127:0]        resp_data;
    logic                resp_err;
    logic                core_ld;
    logic [127:0]        core_key;
    logic [127:0]        core_text_in;
    logic                core_done;
    logic [127:0]        core_text_out;
    logic                busy;
    logic [7:0]          err_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic hang = 1'b0;
    logic force_done = 1'b0;
    logic core_done_m = 1'b0;
    int   core_cnt = 0;
    logic [127:0] core_ct = '0;

    aes_req_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_text(req_text),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
        .core_done(core_done), .core_text_out(core_text_out),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] core_model_ct(input logic [127:0] k, input logic [127:0] t);
        if (k == KEY_FIPS && t == PT_FIPS) return CT_FIPS;
        return {t[63:0], t[127:64]} ^ k ^ 128'hc3c3c3c3_5a5a5a5a_0f0f0f0f_96969696;
    endfunction

    // Stand-in cipher core: done is high 12 cycles after the load pulse.
    always @(posedge clk) begin
        core_done_m <= 1'b0;
        if (core_ld) begin
            core_cnt <= 11;
            core_ct  <= core_model_ct(core_key, core_text_in);
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !hang) core_done_m <= 1'b1;
        end
    end
    assign core_done     = core_done_m | force_done;
    assign core_text_out = core_ct;

    task automatic set_req(input int i, input logic [127:0] k, input logic [127:0] t);
        req_key[128*i +: 128]  = k;
        req_text[128*i +: 128] = t;
    endtask

    task automatic do_reset();
        rst = 1'b0; req_valid = 4'b0000; resp_ready = 1'b0; force_done = 1'b0; hang = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk); #1;
    endtask

    // Waits (bounded) for a handshake in the current cycle; time stays before the next posedge.
    task automatic wait_accept(output int acc_cyc, output int gid, output bit ok);
        ok = 1'b0; acc_cyc = 0; gid = -1;
        for (int n = 0; n < 200; n++) begin
            #1;
            if ((req_ready & req_valid) != 4'b0000) begin
                ok = 1'b1; acc_cyc = cyc;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Waits (bounded) for resp_valid, sampling at negedge+1.
    task automatic wait_resp(output int rcyc, output bit ok, input int limit);
        ok = 1'b0; rcyc = 0;
        for (int n = 0; n < limit; n++) begin
            if (resp_valid === 1'b1) begin
                ok = 1'b1; rcyc = cyc;
                return;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, resp_id, core_ld, busy, err_cnt} !== 18'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h expected 0", {req_ready, resp_valid, resp_err, resp_id, core_ld, busy, err_cnt});
        end
        checks++;
        if ({resp_data, core_key, core_text_in} !== 384'h0) begin
            errors++; $display("FAIL reset_data: got %h %h %h expected 0", resp_data, core_key, core_text_in);
        end
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_rr_ptr: req_ready got %b expected 0001", req_ready);
        end
        req_valid = 4'b0000;
        @(negedge clk); #1;
    endtask

    task automatic test_single_job();
        int acc, g, rc; bit ok;
        do_reset();
        resp_ready = 1'b1;
        set_req(0, KEY_FIPS, PT_FIPS);
        req_valid = 4'b0001;
        wait_accept(acc, g, ok);
        checks++;
        if (!ok || g != 0) begin errors++; $display("FAIL single_grant: got %0d ok=%0d expected 0", g, ok); end
        @(negedge clk); #1;
        req_valid = 4'b0000;
        checks++;
        if (core_ld !== 1'b1 || core_key !== KEY_FIPS || core_text_in !== PT_FIPS || busy !== 1'b1) begin
            errors++; $display("FAIL single_load: ld=%b key=%h text=%h busy=%b expected 1 %h %h 1", core_ld, core_key, core_text_in, busy, KEY_FIPS, PT_FIPS);
        end
        @(negedge clk); #1;
        checks++;
        if (core_ld !== 1'b0) begin errors++; $display("FAIL single_ld_pulse: got %b expected 0", core_ld); end
        wait_resp(rc, ok, 100);
        checks++;
        if (!ok || rc - acc != 14) begin errors++; $display("FAIL single_latency: got %0d expected 14", rc - acc); end
        checks++;
        if (resp_id !== 2'd0 || resp_err !== 1'b0 || resp_data !== CT_FIPS) begin
            errors++; $display("FAIL single_resp: id=%0d err=%b data=%h expected 0 0 %h", resp_id, resp_err, resp_data, CT_FIPS);
        end
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int acc, g, rc; bit ok;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, KEY_FIPS, PT_BASE ^ {96'h0, 32'(i + 1)});
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            wait_accept(acc, g, ok);
            checks++;
            if (!ok || g != (j % NREQ)) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", j, g, j % NREQ); end
            @(negedge clk); #1;
            wait_resp(rc, ok, 100);
            checks++;
            if (!ok || resp_id !== 2'(j % NREQ) || resp_err !== 1'b0 ||
                resp_data !== core_model_ct(KEY_FIPS, PT_BASE ^ {96'h0, 32'((j % NREQ) + 1)})) begin
                errors++; $display("FAIL rr_resp[%0d]: id=%0d err=%b data=%h expected %0d 0 %h", j, resp_id, resp_err, resp_data,
                                   j % NREQ, core_model_ct(KEY_FIPS, PT_BASE ^ {96'h0, 32'((j % NREQ) + 1)}));
            end
            @(negedge clk); #1;
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure();
        int acc, g, rc; bit ok;
        logic [127:0] exp_ct;
        do_reset();
        resp_ready = 1'b0;
        set_req(1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        exp_ct = core_model_ct(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
        req_valid = 4'b0010;
        wait_accept(acc, g, ok);
        checks++;
        if (!ok || g != 1) begin errors++; $display("FAIL bp_grant: got %0d expected 1", g); end
        @(negedge clk); #1;
        req_valid = 4'hF;
        wait_resp(rc, ok, 100);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_err !== 1'b0 || resp_data !== exp_ct ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: v=%b id=%0d err=%b data=%h rdy=%b busy=%b expected 1 1 0 %h 0000 1",
                                   i, resp_valid, resp_id, resp_err, resp_data, req_ready, busy, exp_ct);
            end
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_release: v=%b busy=%b rdy=%b expected 0 0 0100", resp_valid, busy, req_ready);
        end
        req_valid = 4'b0000;
        @(negedge clk); #1;
    endtask

    task automatic test_watchdog();
        int acc, g, rc; bit ok;
        do_reset();
        resp_ready = 1'b1;
        hang = 1'b1;
        set_req(3, KEY_FIPS, PT_BASE);
        req_valid = 4'b1000;
        wait_accept(acc, g, ok);
        @(negedge clk); #1;
        req_valid = 4'b0000;
        wait_resp(rc, ok, 100);
        checks++;
        if (!ok || rc - acc != TIMEOUT + 1) begin errors++; $display("FAIL wd_latency: got %0d expected %0d", rc - acc, TIMEOUT + 1); end
        checks++;
        if (resp_err !== 1'b1 || resp_data !== 128'h0 || err_cnt !== 8'd1 || resp_id !== 2'd3) begin
            errors++; $display("FAIL wd_resp: err=%b data=%h cnt=%0d id=%0d expected 1 0 1 3", resp_err, resp_data, err_cnt, resp_id);
        end
        @(negedge clk); #1;
        hang = 1'b0;
        set_req(0, KEY_FIPS, PT_FIPS);
        req_valid = 4'b0001;
        wait_accept(acc, g, ok);
        @(negedge clk); #1;
        req_valid = 4'b0000;
        wait_resp(rc, ok, 100);
        checks++;
        if (!ok || rc - acc != 14 || resp_err !== 1'b0 || resp_data !== CT_FIPS || err_cnt !== 8'd1 || resp_id !== 2'd0) begin
            errors++; $display("FAIL wd_next_job: lat=%0d err=%b data=%h cnt=%0d id=%0d expected 14 0 %h 1 0",
                               rc - acc, resp_err, resp_data, err_cnt, resp_id, CT_FIPS);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_stale_done();
        int acc, g, rc; bit ok;
        do_reset();
        resp_ready = 1'b1;
        force_done = 1'b1;
        repeat (3) begin @(negedge clk); #1; end
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL stale_idle: busy=%b valid=%b expected 0 0", busy, resp_valid);
        end
        force_done = 1'b0;
        set_req(1, PT_BASE, KEY_FIPS);
        req_valid = 4'b0010;
        wait_accept(acc, g, ok);
        @(negedge clk); #1;
        req_valid = 4'b0000;
        @(negedge clk); #1;
        force_done = 1'b1;
        @(negedge clk); #1;
        force_done = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL stale_first_busy: valid=%b busy=%b expected 0 1", resp_valid, busy);
        end
        wait_resp(rc, ok, 100);
        checks++;
        if (!ok || rc - acc != 14 || resp_id !== 2'd1 || resp_err !== 1'b0 || resp_data !== core_model_ct(PT_BASE, KEY_FIPS)) begin
            errors++; $display("FAIL stale_resp: lat=%0d id=%0d err=%b data=%h expected 14 1 0 %h",
                               rc - acc, resp_id, resp_err, resp_data, core_model_ct(PT_BASE, KEY_FIPS));
        end
        @(negedge clk); #1;
    endtask

    task automatic test_async_reset();
        int acc, g, rc; bit ok;
        do_reset();
        resp_ready = 1'b1;
        set_req(1, KEY_FIPS, PT_BASE);
        set_req(2, PT_BASE, PT_FIPS);
        req_valid = 4'b0010;
        wait_accept(acc, g, ok);
        @(negedge clk); #1;
        req_valid = 4'b0000;
        repeat (6) begin @(negedge clk); #1; end
        rst = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || core_ld !== 1'b0 || core_key !== 128'h0) begin
            errors++; $display("FAIL arst_immediate: busy=%b valid=%b ld=%b key=%h expected 0 0 0 0", busy, resp_valid, core_ld, core_key);
        end
        req_valid = 4'hF; #1;
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready: got %b expected 0000", req_ready); end
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_no_resp: valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
        rst = 1'b1; #1;
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL arst_rr_ptr: req_ready got %b expected 0001", req_ready); end
        req_valid = 4'b0100;
        wait_accept(acc, g, ok);
        checks++;
        if (!ok || g != 2) begin errors++; $display("FAIL arst_grant: got %0d expected 2", g); end
        @(negedge clk); #1;
        req_valid = 4'b0000;
        wait_resp(rc, ok, 100);
        checks++;
        if (!ok || rc - acc != 14 || resp_id !== 2'd2 || resp_err !== 1'b0 || resp_data !== core_model_ct(PT_BASE, PT_FIPS)) begin
            errors++; $display("FAIL arst_job: lat=%0d id=%0d err=%b data=%h expected 14 2 0 %h",
                               rc - acc, resp_id, resp_err, resp_data, core_model_ct(PT_BASE, PT_FIPS));
        end
        @(negedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_back_pressure();
        test_watchdog();
        test_stale_done();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
